rx_ctl: RTL and testbench

UART receive controller: the receive-side counterpart of the transmit controller in the UART_controller design. Recovers 8N1 frames from the `rx` pin using a shared oversampling tick `bclk`, validates start and stop bits, and buffers received bytes in a small show-ahead FIFO. The host side pops bytes with a single-cycle `rd` strobe. It also reports framing errors and FIFO overruns as one-cycle pulses.

---
 rtl/rx_ctl.sv | 171 +++++++++++++++++
 tb/tb_rx_ctl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ctl.sv
// rx_ctl: UART 8N1 receive controller.
// Recovers bytes from the asynchronous rx pin using an oversampling tick
// (bclk) and buffers them in a show-ahead FIFO popped by the host.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bclk       one-clk enable at OVERSAMPLE x baud rate
//   rx         serial input, idles high
//   rd         pop strobe, honoured only while dout_rdy=1
//   dout       FIFO head byte (8'h00 while empty)
//   dout_rdy   FIFO non-empty
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: byte dropped because FIFO was full
module rx_ctl #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bclk,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       dout_rdy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Input synchronizer
  logic r_sync1;
  logic r_rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  // Frame recovery FSM
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitn;
  logic [7:0]    r_sh;
  logic          r_frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bitn      <= '0;
      r_sh        <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!r_rxs) r_state <= S_START;
        end
        S_START: begin
          if (bclk) begin
            if (r_cnt == HALF) begin
              if (r_rxs) begin
                r_state <= S_IDLE;
              end else begin
                r_cnt   <= '0;
                r_bitn  <= '0;
                r_state <= S_DATA;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_DATA: begin
          if (bclk) begin
            if (r_cnt == LAST) begin
              r_sh  <= {r_rxs, r_sh[7:1]};
              r_cnt <= '0;
              if (r_bitn == 3'd7) r_state <= S_STOP;
              else                r_bitn  <= r_bitn + 3'd1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_STOP: begin
          if (bclk) begin
            if (r_cnt == LAST) begin
              r_cnt <= '0;
              if (r_rxs) begin
                r_state <= S_IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= S_BREAK;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_BREAK: begin
          // Held-low line must return high before a new start is accepted
          if (r_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Push happens on the stop-bit sample cycle itself
  logic w_push;
  assign w_push = (r_state == S_STOP) && bclk && (r_cnt == LAST) && r_rxs;

  // Show-ahead FIFO; pointers carry an extra wrap bit
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_overrun;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_wr;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = rd && !w_empty;
  // When full, a simultaneous pop frees the head slot, which is the write slot
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr)  r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_sh;
  end

  assign dout      = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign dout_rdy  = !w_empty;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_rx_ctl.sv
module tb_rx_ctl;

  localparam int OS    = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bclk = 1'b1;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       dout_rdy;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  int exp_fe   = 0;
  int exp_ovr  = 0;
  int fe_seen  = 0;
  int ovr_seen = 0;

  rx_ctl #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bclk      (bclk),
    .rx        (rx),
    .rd        (rd),
    .dout      (dout),
    .dout_rdy  (dout_rdy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters: a pulse stuck high for N cycles counts N times
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_seen++;
    if (overrun === 1'b1)   ovr_seen++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Drives one 8N1 frame (10 bits x OS clk, bclk every cycle).
  // rise = negedge index at which dout_rdy went 0->1, -1 if none.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                            input bit pop_at_push, output int rise);
    logic [9:0] bits;
    logic       prev;
    bits = {stop_ok, b, 1'b0};
    prev = dout_rdy;
    rise = -1;
    for (int k = 0; k < 10 * OS; k++) begin
      @(negedge clk);
      if (k > 0 && dout_rdy === 1'b1 && prev === 1'b0 && rise < 0) rise = k;
      prev = dout_rdy;
      if (pop_at_push && k == 154) begin
        checks++;
        if (dout !== exp_q[0])
          $display("FAIL pushpop_head: dout=%02h expected %02h", dout, exp_q[0]);
        if (dout !== exp_q[0]) failures++;
        rd = 1'b1;
      end
      if (pop_at_push && k == 155) begin
        rd = 1'b0;
        void'(exp_q.pop_front());
      end
      rx = bits[k / OS];
    end
    if (stop_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      exp_ovr++;
    end else begin
      exp_fe++;
    end
  endtask

  // Pops one byte, comparing against the scoreboard head
  task automatic pop_check(input string tag);
    @(negedge clk);
    checks++;
    if (dout_rdy !== (exp_q.size() > 0)) begin
      $display("FAIL %s_rdy: dout_rdy=%b expected %b", tag, dout_rdy, exp_q.size() > 0);
      failures++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      if (dout !== exp_q[0]) begin
        $display("FAIL %s_data: dout=%02h expected %02h", tag, dout, exp_q[0]);
        failures++;
      end
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (fe_seen !== exp_fe) begin
      $display("FAIL %s_frame_err: pulses=%0d expected %0d", tag, fe_seen, exp_fe);
      failures++;
    end
    checks++;
    if (ovr_seen !== exp_ovr) begin
      $display("FAIL %s_overrun: pulses=%0d expected %0d", tag, ovr_seen, exp_ovr);
      failures++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dout_rdy, frame_err, overrun} !== 3'b000 || dout !== 8'h00) begin
      $display("FAIL reset_outputs: rdy/fe/ovr=%b%b%b dout=%02h expected 000 00",
               dout_rdy, frame_err, overrun, dout);
      failures++;
    end
    rx  = 1'b1;
    rst = 1'b0;
    exp_q.delete();
    idle(40);
    checks++;
    if (dout_rdy !== 1'b0) begin
      $display("FAIL reset_idle: dout_rdy=%b expected 0", dout_rdy);
      failures++;
    end
    check_counts("reset");
  endtask

  task automatic test_single();
    int rise;
    // rd while empty must be ignored
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    checks++;
    if (dout_rdy !== 1'b0 || dout !== 8'h00) begin
      $display("FAIL empty_rd: dout_rdy=%b dout=%02h expected 0 00", dout_rdy, dout);
      failures++;
    end
    send_frame(8'hA5, 1'b1, 1'b0, rise);
    // 2 sync cycles + 1 IDLE->START cycle + 152 ticks
    checks++;
    if (rise !== 3 + OS / 2 + 9 * OS) begin
      $display("FAIL single_latency: rdy rose at %0d expected %0d", rise, 3 + OS / 2 + 9 * OS);
      failures++;
    end
    idle(8);
    pop_check("single");
    pop_check("single_empty");
    check_counts("single");
  endtask

  task automatic test_false_start();
    int rise;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(7);
    checks++;
    if (dout_rdy !== 1'b0) begin
      $display("FAIL false_start_push: dout_rdy=%b expected 0", dout_rdy);
      failures++;
    end
    send_frame(8'h96, 1'b1, 1'b0, rise);
    idle(10);
    pop_check("after_false");
    pop_check("after_false_empty");
    check_counts("false_start");
  endtask

  task automatic test_framing();
    int rise;
    send_frame(8'h3C, 1'b0, 1'b0, rise);
    repeat (40) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(20);
    checks++;
    if (dout_rdy !== 1'b0) begin
      $display("FAIL framing_discard: dout_rdy=%b expected 0", dout_rdy);
      failures++;
    end
    check_counts("framing");
    send_frame(8'h5A, 1'b1, 1'b0, rise);
    idle(10);
    pop_check("after_break");
    pop_check("after_break_empty");
  endtask

  task automatic test_overrun();
    int rise;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, rise);
    idle(20);
    check_counts("overrun");
    for (int i = 0; i < 4; i++) pop_check("overrun_drain");
    pop_check("overrun_empty");
  endtask

  task automatic test_back_to_back_pushpop();
    int rise;
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b0, rise);
    send_frame(8'h77, 1'b1, 1'b1, rise);
    idle(20);
    check_counts("pushpop");
    for (int i = 0; i < 4; i++) pop_check("pushpop_drain");
    pop_check("pushpop_empty");
  endtask

  task automatic test_reset_mid_frame();
    int rise;
    logic [9:0] bits;
    bits = {1'b1, 8'h0F, 1'b0};
    for (int k = 0; k < 4 * OS + OS / 2; k++) begin
      @(negedge clk);
      rx = bits[k / OS];
    end
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(200);
    checks++;
    if (dout_rdy !== 1'b0) begin
      $display("FAIL midreset_abandon: dout_rdy=%b expected 0", dout_rdy);
      failures++;
    end
    send_frame(8'hC3, 1'b1, 1'b0, rise);
    idle(10);
    pop_check("midreset");
    pop_check("midreset_empty");
    check_counts("midreset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_false_start();
    test_framing();
    test_overrun();
    test_back_to_back_pushpop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
